// File: rtl/vt_pkg.sv
// Shared types and constants for the Apple 1 video-terminal character sender.
// Holds the FSM state enum, the 7-bit character type, the ASCII constants used
// by the optional uppercase fold and the fold helper itself.
package vt_pkg;

  typedef logic [6:0] vt_char_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } vt_state_e;

  // Lowercase range folded onto uppercase by clearing the 0x20 bit.
  localparam vt_char_t ASCII_LC_A       = 7'h61;
  localparam vt_char_t ASCII_LC_Z       = 7'h7A;
  localparam vt_char_t ASCII_CASE_BIT   = 7'h20;
  // DEL has no glyph in the Apple 1 ROM; it is shown as an underscore.
  localparam vt_char_t ASCII_DEL        = 7'h7F;
  localparam vt_char_t ASCII_UNDERSCORE = 7'h5F;

  // Map a character onto the uppercase-only Apple 1 character set.
  function automatic vt_char_t vt_fold_char(input vt_char_t c);
    vt_char_t r;
    r = c;
    if (c == ASCII_DEL) begin
      r = ASCII_UNDERSCORE;
    end else if ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z)) begin
      r = c & ~ASCII_CASE_BIT;
    end
    return r;
  endfunction

endpackage

// File: rtl/vt_sync_fifo.sv
// Single-clock FIFO for the character sender.
// Pointers carry one extra wrap bit so full/empty come from a plain compare of
// the registered pointers. A pop in the same cycle as a write at full frees
// the slot being written, so that write is accepted. A write that finds no
// room is dropped and latches the sticky overflow flag.
module vt_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_en_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              do_wr, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop = pop_i && !empty_o;
  assign do_wr  = wr_en_i && (!full_o || do_pop);

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf_o     = ovf_q;

  // Next pointer values and sticky overflow accumulation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr_en_i && !do_wr) begin
      ovf_d = 1'b1;
    end
  end

  // Control state: pointers and overflow flag, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/vt_char_sender.sv
// Host-side character transmitter for the Apple 1 video terminal.
// Queues host characters and hands them to the terminal one at a time with a
// data-available strobe, using the terminal's ready/busy line as handshake.
// Optional build macro VT_SENDER_UCASE_FOLD_EN folds lowercase to uppercase
// and DEL to underscore as characters enter the queue.
module vt_char_sender
  import vt_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DA_HOLD     = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic [6:0] rd_out,
  output logic       da_out,
  input  logic       rda_in,
  output logic       busy,
  output logic       ovf
);

  localparam logic [7:0]  HOLD_LAST = 8'(DA_HOLD - 1);
  localparam logic [15:0] TO_LAST   = 16'(ACK_TIMEOUT - 1);

  vt_state_e state_q;
  vt_char_t  rd_q;
  logic      da_q;
  logic [7:0]  hold_cnt_q;
  logic [15:0] to_cnt_q;

  logic      sync1_q, rda_s_q;
  vt_char_t  wr_char;
  vt_char_t  fifo_head;
  logic      fifo_full, fifo_empty, fifo_ovf;
  logic      pop;

`ifdef VT_SENDER_UCASE_FOLD_EN
  assign wr_char = vt_fold_char(wr_data);
`else
  assign wr_char = wr_data;
`endif

  vt_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (7)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (wr_char),
    .wr_en_i   (wr_en),
    .pop_i     (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ovf_o     (fifo_ovf)
  );

  // A character leaves the queue only from IDLE with a ready terminal.
  assign pop = (state_q == ST_IDLE) && !fifo_empty && rda_s_q;

  // Two-flop synchronizer for the terminal ready line; idles at "ready".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rda_s_q <= 1'b1;
    end else begin
      sync1_q <= rda_in;
      rda_s_q <= sync1_q;
    end
  end

  // Handshake sequencer: owns rd_out, da_out and the strobe/timeout counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      da_q       <= 1'b0;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            rd_q    <= fifo_head;
            state_q <= ST_SETUP;
          end
        end
        // One cycle of settled data ahead of the strobe.
        ST_SETUP: begin
          da_q       <= 1'b1;
          hold_cnt_q <= HOLD_LAST;
          state_q    <= ST_STROBE;
        end
        ST_STROBE: begin
          if (hold_cnt_q == 8'd0) begin
            da_q     <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= ST_ACK;
          end else begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end
        end
        // Terminal should go busy; give up after the timeout so a missed
        // strobe cannot wedge the queue.
        ST_ACK: begin
          if (!rda_s_q || (to_cnt_q == TO_LAST)) begin
            state_q <= ST_RECOVER;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        ST_RECOVER: begin
          if (rda_s_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          da_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_out = rd_q;
  assign da_out = da_q;
  assign full   = fifo_full;
  assign ovf    = fifo_ovf;
  // Built only from registered state, so it moves the cycle after a write/pop.
  assign busy   = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_vt_char_sender.sv
// Self-checking bench for vt_char_sender: directed handshake scenarios plus a
// randomized stream, scored against a queue-based model of the character
// stream and a behavioural terminal.
module tb_vt_char_sender;

  localparam int DEPTH       = 16;
  localparam int DA_HOLD     = 4;
  localparam int ACK_TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       full;
  logic [6:0] rd_out;
  logic       da_out;
  logic       rda_in;
  logic       busy;
  logic       ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int strobes = 0;

  logic [6:0] exp_q [$];

  // Terminal behaviour: mode 0 = level driven by term_level,
  // 1 = busy for busy_len cycles after each strobe, 3 = random busy length.
  int   term_mode  = 0;
  logic term_level = 1'b1;
  int   busy_len   = 20;
  logic rda_auto   = 1'b1;

  assign rda_in = (term_mode == 0) ? term_level : rda_auto;

  vt_char_sender #(
    .DEPTH       (DEPTH),
    .DA_HOLD     (DA_HOLD),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .rd_out  (rd_out),
    .da_out  (da_out),
    .rda_in  (rda_in),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Character the terminal should receive for a given host character.
  function automatic logic [6:0] model_char(input logic [6:0] c);
`ifdef VT_SENDER_UCASE_FOLD_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'd32;
    if (c == 7'h7F) return 7'h5F;
`endif
    return c;
  endfunction

  // Behavioural terminal: goes busy one cycle after seeing the strobe rise.
  initial begin : terminal
    logic pend;
    logic prev;
    int   cnt;
    pend = 1'b0; prev = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || term_mode == 0) begin
        pend = 1'b0; cnt = 0; rda_auto = 1'b1;
      end else if (pend) begin
        rda_auto = 1'b0;
        cnt = ((term_mode == 3) ? int'($urandom_range(12, 3)) : busy_len) - 1;
        pend = 1'b0;
      end else if (cnt > 0) begin
        rda_auto = 1'b0;
        cnt--;
      end else begin
        rda_auto = 1'b1;
      end
      if (!rst && term_mode != 0 && da_out && !prev) pend = 1'b1;
      prev = rst ? 1'b0 : da_out;
    end
  end

  // Scoreboard: every strobe must carry the oldest outstanding character
  // and last exactly DA_HOLD cycles.
  initial begin : monitor
    logic prev;
    int   width;
    prev = 1'b0; width = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0; width = 0;
      end else begin
        if (da_out && !prev) begin
          strobes++;
          width = 1;
          if (exp_q.size() == 0) chk("spurious_da", 32'(da_out), 32'd0);
          else chk("char", 32'(rd_out), 32'(exp_q.pop_front()));
        end else if (da_out) begin
          width++;
        end else if (prev) begin
          chk("da_width", width, DA_HOLD);
        end
        prev = da_out;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_char(input logic [6:0] c);
    wr_en = 1'b1;
    wr_data = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_busy_low(input string tag, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_rise(input string tag, input int budget);
    int n;
    n = 0;
    while (!da_out && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(da_out), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    rst = 1'b0;
    tick();
  endtask

  initial begin : main
    int n;
    int s0;
    int t0;
    int t1;
    logic [6:0] c;
    logic [6:0] exp_a;
    logic [6:0] exp_del;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_da_held", 32'(da_out), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_da_out", 32'(da_out), 32'd0);
    chk("rst_full",   32'(full),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_ovf",    32'(ovf),    32'd0);

    // Single character with a 20-cycle busy terminal
    term_mode = 1;
    busy_len  = 20;
    exp_q.push_back(model_char(7'h41));
    write_char(7'h41);
    chk("t1_busy_p1", 32'(busy), 32'd1);
    chk("t1_da_p1", 32'(da_out), 32'd0);
    tick();
    chk("t1_rd_p2", 32'(rd_out), 32'h41);
    chk("t1_da_p2", 32'(da_out), 32'd0);
    tick();
    chk("t1_da_p3", 32'(da_out), 32'd1);
    wait_busy_low("t1_idle", 100, n);
    chk("t1_busy_window", 32'(n > 20 && n < 40), 32'd1);
    chk("t1_rd_hold", 32'(rd_out), 32'h41);

    // Burst of 17 with the terminal busy: 16 stored, 17th dropped
    term_mode  = 0;
    term_level = 1'b0;
    repeat (4) tick();
    s0 = strobes;
    for (int i = 0; i < 17; i++) begin
      chk("t2_full", 32'(full), 32'(i >= 16));
      chk("t2_ovf_early", 32'(ovf), 32'd0);
      wr_en = 1'b1;
      wr_data = 7'(8'h30 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("t2_full_end", 32'(full), 32'd1);
    chk("t2_ovf_set", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(7'(8'h30 + i));
    repeat (10) tick();
    chk("t2_no_strobe", strobes - s0, 0);
    term_mode = 3;
    wait_busy_low("t2_drain", 2000, n);
    chk("t2_count", strobes - s0, 16);
    chk("t2_left", exp_q.size(), 0);
    chk("t2_ovf_sticky", 32'(ovf), 32'd1);

    do_reset();
    chk("rst2_ovf_clear", 32'(ovf), 32'd0);

    // Write at full in the same cycle as a pop
    term_mode  = 0;
    term_level = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = 7'(8'h41 + i);
      exp_q.push_back(7'(8'h41 + i));
      tick();
    end
    wr_en = 1'b0;
    chk("t4_full", 32'(full), 32'd1);
    s0 = strobes;
    term_level = 1'b1;
    tick();
    tick();
    chk("t4_full_at_wr", 32'(full), 32'd1);
    wr_en = 1'b1;
    wr_data = 7'h51;
    exp_q.push_back(7'h51);
    tick();
    wr_en = 1'b0;
    chk("t4_ovf", 32'(ovf), 32'd0);
    chk("t4_full_after", 32'(full), 32'd1);
    chk("t4_rd_popped", 32'(rd_out), 32'h41);
    term_mode = 3;
    wait_busy_low("t4_drain", 2000, n);
    chk("t4_count", strobes - s0, 17);
    chk("t4_left", exp_q.size(), 0);

    // Terminal never goes busy: each char waits out the ack timeout
    term_mode  = 0;
    term_level = 1'b1;
    exp_q.push_back(7'h54);
    exp_q.push_back(7'h55);
    wr_en = 1'b1;
    wr_data = 7'h54;
    tick();
    wr_data = 7'h55;
    tick();
    wr_en = 1'b0;
    wait_rise("t3_rise1", 20);
    t0 = cyc;
    n = 0;
    while (da_out && n < 20) begin
      tick();
      n++;
    end
    wait_rise("t3_rise2", 1200);
    t1 = cyc;
    chk("t3_gap", t1 - t0, DA_HOLD + ACK_TIMEOUT + 3);
    wait_busy_low("t3_drain", 1200, n);
    chk("t3_left", exp_q.size(), 0);

    // Reset during the strobe
    term_mode = 3;
    exp_q.push_back(7'h42);
    write_char(7'h42);
    wait_rise("t5_rise", 20);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_da_async", 32'(da_out), 32'd0);
    chk("t5_rd_clear", 32'(rd_out), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_full", 32'(full), 32'd0);
    tick();
    tick();
    exp_q.delete();
    rst = 1'b0;
    tick();
    exp_q.push_back(model_char(7'h43));
    write_char(7'h43);
    wait_busy_low("t5_after", 200, n);
    chk("t5_left", exp_q.size(), 0);

    // Fold of lowercase and DEL (identity when the feature is off)
`ifdef VT_SENDER_UCASE_FOLD_EN
    exp_a   = 7'h41;
    exp_del = 7'h5F;
`else
    exp_a   = 7'h61;
    exp_del = 7'h7F;
`endif
    exp_q.push_back(exp_a);
    write_char(7'h61);
    tick();
    chk("t6_fold_a", 32'(rd_out), 32'(exp_a));
    wait_busy_low("t6_idle_a", 200, n);
    exp_q.push_back(exp_del);
    write_char(7'h7F);
    tick();
    chk("t6_fold_del", 32'(rd_out), 32'(exp_del));
    wait_busy_low("t6_idle_del", 200, n);

    // Randomized stream from a host that respects full
    term_mode = 3;
    for (int k = 0; k < 60; k++) begin
      n = 0;
      while (full && n < 200) begin
        tick();
        n++;
      end
      chk("rand_room", 32'(full), 32'd0);
      c = 7'($urandom_range(8'h7F, 8'h20));
      exp_q.push_back(model_char(c));
      write_char(c);
      repeat ($urandom_range(3, 0)) tick();
    end
    wait_busy_low("rand_drain", 3000, n);
    chk("rand_left", exp_q.size(), 0);
    chk("rand_ovf", 32'(ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
